// File: rtl/agc_snapshot_buffer_if.sv
// AXI4-Stream link that carries packed snapshot words out of agc_snapshot_buffer.
interface agc_snapshot_buffer_if #(
   parameter int DW = 128
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/agc_snapshot_buffer.sv
// Post-AGC snapshot capture: circular pre/post-trigger recording into BRAM, then an
// in-order replay of the frozen window on an AXI4-Stream master with a 2-entry skid.
module agc_snapshot_buffer #(
   parameter int DEPTH_LOG2 = 10,
   parameter int NSAMP      = 8,
   parameter int SAMPBITS   = 5
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NSAMP*SAMPBITS-1:0] dat_i,
   input  logic                      arm_i,
   input  logic                      trig_i,
   input  logic [DEPTH_LOG2-1:0]     pretrig_i,
   agc_snapshot_buffer_if.master     m_axis,
   output logic                      busy_o,
   output logic                      done_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DW    = NSAMP * SAMPBITS;
   localparam int CW    = DEPTH_LOG2 + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_READ} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DW-1:0]         r_mem [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] r_p;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_rd_cnt;
   logic [DW-1:0]         r_rd_data;
   logic                  r_rd_vld;
   logic                  r_rd_last;
   logic [DW-1:0]         r_slot0;
   logic [DW-1:0]         r_slot1;
   logic                  r_vld0;
   logic                  r_vld1;
   logic                  r_last0;
   logic                  r_last1;
   logic                  r_done;
   logic                  r_busy;
   logic [CW-1:0]         w_post_len;
   logic                  w_wr_en;
   logic                  w_pop;
   logic                  w_issue;
   logic [2:0]            w_level;

   assign w_post_len = CW'(DEPTH) - {1'b0, r_p};
   assign w_pop      = r_vld0 & m_axis.tready;
   assign w_wr_en    = (r_state == ST_PRE) || (r_state == ST_ARMED) ||
                       ((r_state == ST_POST) && (r_cnt != w_post_len));
   // Words held or in flight after this clock; a new read is issued only if it will fit.
   assign w_level    = {2'b00, r_vld0} + {2'b00, r_vld1} + {2'b00, r_rd_vld} - {2'b00, w_pop};
   assign w_issue    = (r_state == ST_READ) && (r_rd_cnt != CW'(DEPTH)) && (w_level < 3'd2);

   // State register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (arm_i) begin
               w_state_nxt = (pretrig_i != '0) ? ST_PRE : ST_ARMED;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PRE: begin
            if ((r_cnt + CW'(1)) == {1'b0, r_p}) begin
               w_state_nxt = ST_ARMED;
            end else begin
               w_state_nxt = ST_PRE;
            end
         end
         ST_ARMED: begin
            if (trig_i) begin
               w_state_nxt = ST_POST;
            end else begin
               w_state_nxt = ST_ARMED;
            end
         end
         ST_POST: begin
            if (r_cnt == w_post_len) begin
               w_state_nxt = ST_READ;
            end else begin
               w_state_nxt = ST_POST;
            end
         end
         ST_READ: begin
            if (w_pop && r_last0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Snapshot storage: one write port, registered read port
   always_ff @(posedge aclk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= dat_i;
      end
      r_rd_data <= r_mem[r_rd_ptr];
   end

   // Capture pointers, readout sequencing and output skid buffer
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_p       <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_rd_cnt  <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
         r_slot0   <= '0;
         r_slot1   <= '0;
         r_vld0    <= 1'b0;
         r_vld1    <= 1'b0;
         r_last0   <= 1'b0;
         r_last1   <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (arm_i) begin
                  r_p      <= pretrig_i;
                  r_wr_ptr <= '0;
                  r_cnt    <= '0;
                  r_rd_cnt <= '0;
               end
            end
            ST_PRE: begin
               r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
               r_cnt    <= r_cnt + CW'(1);
            end
            ST_ARMED: begin
               r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
               if (trig_i) begin
                  // The sample written this clock becomes entry P of the window.
                  r_rd_ptr <= r_wr_ptr - r_p;
                  r_cnt    <= CW'(1);
               end
            end
            ST_POST: begin
               if (w_wr_en) begin
                  r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                  r_cnt    <= r_cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase

         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_rd_cnt <= r_rd_cnt + CW'(1);
         end
         r_rd_vld  <= w_issue;
         r_rd_last <= w_issue && (r_rd_cnt == CW'(DEPTH - 1));

         if (w_pop) begin
            if (r_vld1) begin
               r_slot0 <= r_slot1;
               r_last0 <= r_last1;
               if (r_rd_vld) begin
                  r_slot1 <= r_rd_data;
                  r_last1 <= r_rd_last;
               end else begin
                  r_vld1  <= 1'b0;
                  r_last1 <= 1'b0;
               end
            end else if (r_rd_vld) begin
               r_slot0 <= r_rd_data;
               r_last0 <= r_rd_last;
            end else begin
               r_vld0  <= 1'b0;
               r_last0 <= 1'b0;
            end
         end else if (r_rd_vld) begin
            if (!r_vld0) begin
               r_slot0 <= r_rd_data;
               r_last0 <= r_rd_last;
               r_vld0  <= 1'b1;
            end else begin
               r_slot1 <= r_rd_data;
               r_last1 <= r_rd_last;
               r_vld1  <= 1'b1;
            end
         end

         r_done <= w_pop && r_last0;
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   // Pack5 layout: each sample lands in bits [12:8] of its 16-bit lane
   always_comb begin
      m_axis.tdata = '0;
      for (int i = 0; i < NSAMP; i++) begin
         m_axis.tdata[16*i+8 +: SAMPBITS] = r_slot0[SAMPBITS*i +: SAMPBITS];
      end
   end

   assign m_axis.tvalid = r_vld0;
   assign m_axis.tlast  = r_last0;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
endmodule

// File: tb/tb_agc_snapshot_buffer.sv
// Scoreboard bench for agc_snapshot_buffer: the expected window is built from the
// driven samples and compared word by word against the AXI4-Stream output.
module tb_agc_snapshot_buffer;
   localparam int DEPTH = 1024;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [39:0]   dat_i;
   logic          arm_i;
   logic          trig_i;
   logic [9:0]    pretrig_i;
   logic          busy_o;
   logic          done_o;
   logic [39:0]   smp;
   logic [127:0]  exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;

   agc_snapshot_buffer_if m_axis ();

   agc_snapshot_buffer #(.DEPTH_LOG2(10), .NSAMP(8), .SAMPBITS(5)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .dat_i     (dat_i),
      .arm_i     (arm_i),
      .trig_i    (trig_i),
      .pretrig_i (pretrig_i),
      .m_axis    (m_axis),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pack(input logic [39:0] s);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[16*i+8 +: 5] = s[5*i +: 5];
      end
      return w;
   endfunction

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // One arm/trigger/readout cycle. abort_post >= 0 resets that many clocks after the
   // trigger; abort_word >= 0 resets while that word is being presented.
   task automatic run_capture(input int p, input int k, input int ready_pct, input bit spurious,
                              input int abort_post, input int abort_word);
      logic [39:0]  hist [$];
      logic [127:0] prev_data;
      logic         prev_last;
      int  tc;
      int  post_left;
      int  words;
      int  first_v;
      int  gaps;
      bit  exp_done;
      bit  seen_done;
      bit  stalled;
      tc        = p + 1 + k;
      post_left = 0;
      words     = 0;
      first_v   = -1;
      gaps      = 0;
      exp_done  = 1'b0;
      seen_done = 1'b0;
      stalled   = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      exp_q.delete();
      pretrig_i = p[9:0];

      if (spurious) begin
         trig_i = 1'b1;
         step();
         trig_i = 1'b0;
         check("idle_trig_busy", 128'(busy_o), 128'(0));
      end

      for (int c = 0; c < tc + 4 * DEPTH + 50; c++) begin
         m_axis.tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);

         check("done", 128'(done_o), 128'(exp_done));
         if (exp_done) begin
            seen_done = 1'b1;
            check("busy_after_done", 128'(busy_o), 128'(0));
            break;
         end
         if (c == 2) begin
            check("busy_capture", 128'(busy_o), 128'(1));
         end

         if ((abort_post >= 0 && c == tc + abort_post) ||
             (abort_word >= 0 && words == abort_word && m_axis.tvalid)) begin
            arm_i   = 1'b0;
            trig_i  = 1'b0;
            aresetn = 1'b0;
            step();
            check("abort_tvalid", 128'(m_axis.tvalid), 128'(0));
            check("abort_busy", 128'(busy_o), 128'(0));
            check("abort_tlast", 128'(m_axis.tlast), 128'(0));
            aresetn = 1'b1;
            step();
            return;
         end

         if (stalled) begin
            check("hold_valid", 128'(m_axis.tvalid), 128'(1));
            check("hold_data", m_axis.tdata, prev_data);
            check("hold_last", 128'(m_axis.tlast), 128'(prev_last));
         end
         if (m_axis.tvalid && first_v < 0) begin
            first_v = c;
         end
         if (first_v >= 0 && words < DEPTH && !m_axis.tvalid) begin
            gaps++;
         end
         if (m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 128'(exp_q.size()), 128'(1));
            end else begin
               check("word", m_axis.tdata, exp_q.pop_front());
            end
            check("tlast", 128'(m_axis.tlast), 128'(words == DEPTH - 1));
            words++;
            exp_done = (words == DEPTH);
         end
         stalled   = m_axis.tvalid && !m_axis.tready;
         prev_data = m_axis.tdata;
         prev_last = m_axis.tlast;

         dat_i  = smp;
         arm_i  = (c == 0) ||
                  (spurious && (c == tc + 5 || (first_v >= 0 && c == first_v + 3)));
         trig_i = (c == tc) || (spurious && (c == 0 || c == 1));

         if (c >= 1 && c < tc) begin
            hist.push_back(smp);
            while (hist.size() > p) begin
               void'(hist.pop_front());
            end
         end else if (c == tc) begin
            foreach (hist[j]) begin
               exp_q.push_back(pack(hist[j]));
            end
            exp_q.push_back(pack(smp));
            post_left = DEPTH - p - 1;
         end else if (c > tc && post_left > 0) begin
            exp_q.push_back(pack(smp));
            post_left--;
         end else begin
         end
         smp = smp + 40'd1;
         step();
         arm_i  = 1'b0;
         trig_i = 1'b0;
      end

      check("done_seen", 128'(seen_done), 128'(1));
      check("word_count", 128'(words), 128'(DEPTH));
      check("sb_left", 128'(exp_q.size()), 128'(0));
      check("first_valid_latency", 128'(first_v >= 0 && first_v <= tc + DEPTH - p + 4), 128'(1));
      if (ready_pct >= 100) begin
         check("gaps", 128'(gaps), 128'(0));
      end
      m_axis.tready = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      aresetn       = 1'b0;
      dat_i         = '0;
      arm_i         = 1'b0;
      trig_i        = 1'b0;
      pretrig_i     = '0;
      m_axis.tready = 1'b0;
      smp           = 40'h12_3456_789A;
      repeat (3) step();
      check("rst_tvalid", 128'(m_axis.tvalid), 128'(0));
      check("rst_tlast", 128'(m_axis.tlast), 128'(0));
      check("rst_tdata", m_axis.tdata, 128'(0));
      check("rst_busy", 128'(busy_o), 128'(0));
      check("rst_done", 128'(done_o), 128'(0));
      aresetn = 1'b1;
      step();

      run_capture(16, 100, 100, 1'b0, -1, -1);
      run_capture(0, 20, 100, 1'b0, -1, -1);
      run_capture(1023, 10, 100, 1'b0, -1, -1);
      run_capture(16, 100, 50, 1'b0, -1, -1);
      run_capture(16, 100, 100, 1'b1, -1, -1);
      run_capture(16, 3100, 100, 1'b0, -1, -1);
      run_capture(16, 50, 100, 1'b0, 200, -1);
      run_capture(16, 50, 100, 1'b0, -1, 300);
      run_capture(16, 100, 70, 1'b0, -1, -1);
      run_capture(700, 40, 50, 1'b0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
